// File: rtl/arb_pkg.sv
// Shared types and default widths for the single-port memory arbiter.
package arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Owner of the access whose response returns next cycle.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    I    = 2'd1,
    D    = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of cycles a pending fetch has lost arbitration; flags
// when the fetch port must be given priority.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic i_prio
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;

  assign i_prio = (starve_cnt == CW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= '0;
    end else if (!i_prio) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one single-port synchronous memory.
// Optional performance counters are built when ARB_PERF_EN is defined.
//
// state  | meaning
// NONE   | IDLE: no response due next cycle
// I      | I_PEND: fetch read data returns next cycle
// D      | D_PEND: data read data / write ack returns next cycle
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       i_wait_cnt,
  output logic [31:0]       d_wait_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  owner_t owner_q, owner_d;
  logic   i_prio;

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .i_req  (i_req),
    .i_gnt  (i_gnt),
    .i_prio (i_prio)
  );

  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    owner_d = NONE;
    if (!rst) begin
      if (d_req && !(i_req && i_prio)) begin
        d_gnt   = 1'b1;
        owner_d = D;
      end else if (i_req) begin
        i_gnt   = 1'b1;
        owner_d = I;
      end
    end
  end

  assign m_en    = i_gnt | d_gnt;
  assign m_we    = d_gnt & d_we;
  assign m_addr  = d_gnt ? d_addr : i_addr;
  assign m_wdata = d_wdata;

  always_ff @(posedge clk) begin
    if (rst) owner_q <= NONE;
    else     owner_q <= owner_d;
  end

  // Gated by rst so an in-flight response is dropped during reset.
  assign i_rvalid = !rst && (owner_q == I);
  assign d_rvalid = !rst && (owner_q == D);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

`ifdef ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      i_wait_cnt   <= '0;
      d_wait_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (i_req && !i_gnt)  i_wait_cnt   <= i_wait_cnt + 32'd1;
      if (d_req && !d_gnt)  d_wait_cnt   <= d_wait_cnt + 32'd1;
      if (i_req && d_req)   conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter with a response scoreboard and a
// behavioural single-port memory.
module tb_mem_arbiter;
  import arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
`ifdef ARB_PERF_EN
  logic [31:0] i_wait_cnt, d_wait_cnt, conflict_cnt;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef ARB_PERF_EN
    , .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Memory environment.
  logic [31:0] mem [logic [31:0]];
  always @(posedge clk) begin
    if (m_en) begin
      m_rdata <= mem.exists(m_addr) ? mem[m_addr] : init_val(m_addr);
      if (m_we) mem[m_addr] = m_wdata;
    end
  end

  // Expected-content model, kept independent of the environment memory.
  logic [31:0] exp_mem [logic [31:0]];
  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
  endfunction

  typedef struct {
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        ei;
    logic        ed;
  } vec_t;

  typedef struct {
    owner_t      port;
    logic        wr;
    logic [31:0] data;
  } rsp_t;

  rsp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_conf = 0, m_iwait = 0, m_dwait = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    rsp_t e, n;
    @(posedge clk);
    #1;
    rst = v.rst; i_req = v.i_req; i_addr = v.i_addr;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    #4;
    e = q.pop_front();
    if (v.rst) e.port = NONE;
    chk($sformatf("i_rvalid[%0d]", idx), 32'(i_rvalid), 32'(e.port == I));
    chk($sformatf("d_rvalid[%0d]", idx), 32'(d_rvalid), 32'(e.port == D));
    if (e.port == I) chk($sformatf("i_rdata[%0d]", idx), i_rdata, e.data);
    if (e.port == D && !e.wr) chk($sformatf("d_rdata[%0d]", idx), d_rdata, e.data);
    chk($sformatf("i_gnt[%0d]", idx), 32'(i_gnt), 32'(v.ei));
    chk($sformatf("d_gnt[%0d]", idx), 32'(d_gnt), 32'(v.ed));
    chk($sformatf("m_en[%0d]", idx), 32'(m_en), 32'(v.ei | v.ed));
    chk($sformatf("m_we[%0d]", idx), 32'(m_we), 32'(v.ed & v.d_we));
    if (v.ei) chk($sformatf("m_addr_i[%0d]", idx), m_addr, v.i_addr);
    if (v.ed) chk($sformatf("m_addr_d[%0d]", idx), m_addr, v.d_addr);
    if (v.ed && v.d_we) chk($sformatf("m_wdata[%0d]", idx), m_wdata, v.d_wdata);

    n.port = NONE; n.wr = 1'b0; n.data = '0;
    if (!v.rst && v.ei) begin
      n.port = I; n.data = exp_rd(v.i_addr);
    end else if (!v.rst && v.ed) begin
      n.port = D; n.wr = v.d_we;
      if (v.d_we) exp_mem[v.d_addr] = v.d_wdata;
      else        n.data = exp_rd(v.d_addr);
    end
    q.push_back(n);

    if (v.rst) begin
      m_conf = 0; m_iwait = 0; m_dwait = 0;
    end else begin
      if (v.i_req && v.d_req) m_conf++;
      if (v.i_req && !v.ei)   m_iwait++;
      if (v.d_req && !v.ed)   m_dwait++;
    end
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                              input logic dr, input logic dw, input logic [31:0] da,
                              input logic [31:0] wd, input logic ei, input logic ed);
    vec_t v;
    v.rst = r; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da; v.d_wdata = wd; v.ei = ei; v.ed = ed;
    return v;
  endfunction

  initial begin
    rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    begin
      rsp_t z;
      z.port = NONE; z.wr = 1'b0; z.data = '0;
      q.push_back(z);
    end

    //           rst ir ia        dr dw da        wdata          ei ed
    tbl.push_back(mk(1, 1, 32'h100, 1, 0, 32'h200, 32'h0,         0, 0));
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,   32'h0,         0, 0));
    tbl.push_back(mk(0, 1, 32'h100, 0, 0, 32'h0,   32'h0,         1, 0));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,         0, 0));
    tbl.push_back(mk(0, 1, 32'h104, 1, 0, 32'h200, 32'h0,         0, 1));
    tbl.push_back(mk(0, 1, 32'h104, 0, 0, 32'h0,   32'h0,         1, 0));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,         0, 0));
    // Starvation: data wins four times, then the fetch is forced through.
    tbl.push_back(mk(0, 1, 32'h300, 1, 0, 32'h10,  32'h0,         0, 1));
    tbl.push_back(mk(0, 1, 32'h300, 1, 0, 32'h14,  32'h0,         0, 1));
    tbl.push_back(mk(0, 1, 32'h300, 1, 0, 32'h18,  32'h0,         0, 1));
    tbl.push_back(mk(0, 1, 32'h300, 1, 0, 32'h1C,  32'h0,         0, 1));
    tbl.push_back(mk(0, 1, 32'h300, 1, 0, 32'h20,  32'h0,         1, 0));
    tbl.push_back(mk(0, 1, 32'h304, 1, 0, 32'h20,  32'h0,         0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,         0, 0));
    // Back-to-back write then read of the same word.
    tbl.push_back(mk(0, 0, 32'h0,   1, 1, 32'h40,  32'hDEADBEEF,  0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   1, 0, 32'h40,  32'h0,         0, 1));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,         0, 0));

    for (int k = 0; k < tbl.size(); k++) run_vec(tbl[k], k);

    // Reset while a fetch response is in flight: it must be dropped.
    run_vec(mk(0, 1, 32'h80,  0, 0, 32'h0,  32'h0, 1, 0), 100);
    run_vec(mk(1, 1, 32'h80,  1, 1, 32'h44, 32'h5, 0, 0), 101);
    run_vec(mk(0, 0, 32'h0,   0, 0, 32'h0,  32'h0, 0, 0), 102);
    run_vec(mk(0, 0, 32'h0,   1, 0, 32'h40, 32'h0, 0, 1), 103);
    // Three conflict cycles after a fresh reset for the counters.
    run_vec(mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0, 0, 0), 104);
    run_vec(mk(0, 1, 32'h8,   1, 0, 32'h50, 32'h0, 0, 1), 105);
    run_vec(mk(0, 1, 32'h8,   1, 0, 32'h54, 32'h0, 0, 1), 106);
    run_vec(mk(0, 1, 32'h8,   1, 0, 32'h58, 32'h0, 0, 1), 107);
    run_vec(mk(0, 0, 32'h0,   0, 0, 32'h0,  32'h0, 0, 0), 108);

    @(posedge clk);
    #1;
`ifdef ARB_PERF_EN
    chk("conflict_cnt", conflict_cnt, 32'(m_conf));
    chk("i_wait_cnt",   i_wait_cnt,   32'(m_iwait));
    chk("d_wait_cnt",   d_wait_cnt,   32'(m_dwait));
    chk("conflict_cnt_3", conflict_cnt, 32'd3);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width in bits.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive cycles that a pending instruction request may lose arbitration.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 i_req  input  1  fetch port request.
REQ-007 i_addr  input  ADDR_W  fetch port address.
REQ-008 i_gnt  output  1  fetch request accepted this cycle.
REQ-009 i_rvalid  output  1  fetch read data valid.
REQ-010 i_rdata  output  DATA_W  fetch read data.
REQ-011 d_req  input  1  data port request.
REQ-012 d_we  input  1  data port write enable; 1 = write, 0 = read.
REQ-013 d_addr  input  ADDR_W  data port address.
REQ-014 d_wdata  input  DATA_W  data port write data.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  data response valid; this is read data for a read and the write acknowledge for a write.
REQ-017 d_rdata  output  DATA_W  data port read data.
REQ-018 m_en, m_we  output  1 each  memory enable and memory write enable.
REQ-019 m_addr  output  ADDR_W  memory address; m_wdata  output  DATA_W  memory write data.
REQ-020 m_rdata  input  DATA_W  memory read data, valid one cycle after the m_en cycle.

Function
REQ-021 SHALL share one single-port synchronous memory between the fetch port and the data port, with at most one access issued per cycle.
REQ-022 Grant SHALL be combinational within the request cycle; m_en SHALL equal i_gnt | d_gnt; m_addr, m_we and m_wdata SHALL come from the granted port; m_we SHALL be 0 on a fetch grant.
REQ-023 The response SHALL arrive exactly 1 cycle after the grant: owner_q SHALL record the granted port (NONE, I or D), and the owning port's rvalid SHALL be asserted the following cycle with rdata = m_rdata.
REQ-024 Grants SHALL be fully pipelined: a new grant is allowed in the same cycle as the previous access's rvalid, giving one access per cycle of throughput.
REQ-025 Priority: the data port SHALL win when both ports request, except when starve_cnt == STARVE_MAX, in which case the fetch port SHALL win.
REQ-026 starve_cnt SHALL increment, saturating at STARVE_MAX, on each cycle where i_req is 1 and i_gnt is 0; it SHALL clear on i_gnt or when i_req is 0.
REQ-027 A port whose request is not granted SHALL see gnt = 0; the requester holds its request and address until it is granted.
REQ-028 The fsm SHALL have states IDLE (owner_q = NONE), I_PEND and D_PEND; the next state SHALL be chosen from the current-cycle grant only.
REQ-029 The rvalid of a port SHALL never be asserted without a grant to that port 1 cycle earlier.

Reset
REQ-030 While rst is 1: owner_q = NONE, starve_cnt = 0, and all gnt, rvalid and m_en/m_we outputs SHALL be 0; rdata values are don't-care.
REQ-031 Reset mid-operation SHALL drop any in-flight response, so no rvalid is asserted in the cycle after rst deasserts.

Configuration
REQ-032 With ARB_PERF_EN defined, the block SHALL add 32-bit outputs i_wait_cnt, d_wait_cnt and conflict_cnt, which count cycles of request-without-grant per port and cycles with both requests, wrap at 2^32, and clear on rst.
REQ-033 Without ARB_PERF_EN, those ports and counters SHALL be absent and the behaviour SHALL otherwise be identical.

Structure
REQ-034 Package arb_pkg SHALL hold the owner_t enum (NONE, I, D) and the default constants for ADDR_W and DATA_W.
REQ-035 Sub-module arb_starve_ctr SHALL implement the saturating starvation counter and its priority-override flag; everything else SHALL stay in mem_arbiter.

Verification
REQ-036 Lone fetch: i_req=1, i_addr=0x100, d_req=0 -> i_gnt=1 the same cycle, m_addr=0x100, i_rvalid=1 the next cycle with i_rdata = memory[0x100].
REQ-037 Conflict: i_req=1 and d_req=1 (read of 0x200) -> d_gnt=1 and i_gnt=0; d_rvalid follows the next cycle; the fetch is granted the following cycle once d_req drops.
REQ-038 Starvation: i_req=1 and d_req=1 held for 6 cycles with STARVE_MAX=4 -> d_gnt in cycles 0-3, i_gnt in cycle 4, d_gnt in cycle 5.
REQ-039 Write then read: d write 0xDEADBEEF to 0x40, then d read of 0x40 back-to-back -> two consecutive d_gnt cycles, d_rvalid on both following cycles, second d_rdata = 0xDEADBEEF.
REQ-040 Reset mid-access: grant a fetch, then assert rst in the next cycle -> i_rvalid=0 and all outputs at their reset values.
REQ-041 ARB_PERF_EN: 3 conflict cycles -> conflict_cnt=3 and i_wait_cnt=3.
